// File: rtl/apb2_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : apb2_slave_regs_if
// Desc     : APB2 (AMBA 2) bus bundle with master and slave views.
// Revision : 1.0
// ============================================================================
interface apb2_slave_regs_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  pselx;
    logic                  pwrite;
    logic                  penable;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        output pselx,
        output pwrite,
        output penable,
        output paddr,
        output pwdata,
        input  prdata
    );

    modport slave (
        input  pselx,
        input  pwrite,
        input  penable,
        input  paddr,
        input  pwdata,
        output prdata
    );
endinterface
`default_nettype wire

// File: rtl/apb2_slave_regs.sv
`default_nettype none
// ============================================================================
// Module   : apb2_slave_regs
// Desc     : APB2 responder with a NUM_REGS word register bank and bus-phase
//            tracker; protocol checker enabled by APB2_SLAVE_PROT_CHECK_EN.
// Revision : 1.0
// ============================================================================
module apb2_slave_regs #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA2B2_0001
) (
    input  logic                           pclk,
    input  logic                           preset,
    apb2_slave_regs_if.slave               bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic                           wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0]    wr_idx,
    output logic                           prot_err,
    output logic [7:0]                     err_count,
    input  logic                           err_clr
);
    localparam int C_IDX_W = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [C_IDX_W-1:0]    wr_idx_q, wr_idx_d;

    logic [C_IDX_W-1:0]    w_idx;
    logic                  w_in_range;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_commit;

    assign w_idx      = bus.paddr[C_IDX_W+1:2];
    assign w_in_range = ({{(32-ADDR_WIDTH){1'b0}}, bus.paddr} < 32'(4 * NUM_REGS));
    assign w_setup    = bus.pselx & ~bus.penable;

`ifdef APB2_SLAVE_PROT_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] setup_addr_q, setup_addr_d;
    logic                  setup_write_q, setup_write_d;
    logic                  prot_err_q, prot_err_d;
    logic [7:0]            err_count_q, err_count_d;
    logic                  w_violation;

    // State lags the bus by one cycle: SETUP is held while the access phase is on the bus.
    always_comb begin
        state_d       = w_setup ? ST_SETUP : ST_IDLE;
        setup_addr_d  = setup_addr_q;
        setup_write_d = setup_write_q;
        w_access      = 1'b0;
        w_violation   = 1'b0;
        case (state_q)
            ST_SETUP: begin
                if (bus.pselx && bus.penable && (bus.paddr == setup_addr_q) &&
                    (bus.pwrite == setup_write_q)) begin
                    w_access = 1'b1;
                    state_d  = ST_ACCESS;
                end else begin
                    w_violation = 1'b1;
                end
            end
            default: begin
                if (bus.pselx && bus.penable) begin
                    w_violation = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
        endcase
        if (w_setup) begin
            setup_addr_d  = bus.paddr;
            setup_write_d = bus.pwrite;
        end

        prot_err_d  = prot_err_q;
        err_count_d = err_count_q;
        if (w_violation) begin
            prot_err_d  = 1'b1;
            err_count_d = err_clr ? 8'd1 :
                          (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
        end else if (err_clr) begin
            prot_err_d  = 1'b0;
            err_count_d = 8'd0;
        end
    end

    assign prot_err  = prot_err_q;
    assign err_count = err_count_q;
`else
    logic unused_err_clr;

    assign w_access       = bus.pselx & bus.penable;
    assign prot_err       = 1'b0;
    assign err_count      = 8'd0;
    assign unused_err_clr = err_clr;
`endif

    assign w_commit = w_access & bus.pwrite & w_in_range & (w_idx != '0);

    always_comb begin
        regs_d      = regs_q;
        prdata_d    = prdata_q;
        wr_strobe_d = 1'b0;
        wr_idx_d    = wr_idx_q;
        if (w_setup && !bus.pwrite) begin
            if (!w_in_range) begin
                prdata_d = '0;
            end else if (w_idx == '0) begin
                prdata_d = ID_VALUE;
            end else begin
                prdata_d = regs_q[w_idx];
            end
        end
        if (w_commit) begin
            regs_d[w_idx] = bus.pwdata;
            wr_strobe_d   = 1'b1;
            wr_idx_d      = w_idx;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            regs_q        <= '{default: '0};
            prdata_q      <= '0;
            wr_strobe_q   <= 1'b0;
            wr_idx_q      <= '0;
`ifdef APB2_SLAVE_PROT_CHECK_EN
            state_q       <= ST_IDLE;
            setup_addr_q  <= '0;
            setup_write_q <= 1'b0;
            prot_err_q    <= 1'b0;
            err_count_q   <= 8'd0;
`endif
        end else begin
            regs_q        <= regs_d;
            prdata_q      <= prdata_d;
            wr_strobe_q   <= wr_strobe_d;
            wr_idx_q      <= wr_idx_d;
`ifdef APB2_SLAVE_PROT_CHECK_EN
            state_q       <= state_d;
            setup_addr_q  <= setup_addr_d;
            setup_write_q <= setup_write_d;
            prot_err_q    <= prot_err_d;
            err_count_q   <= err_count_d;
`endif
        end
    end

    assign bus.prdata = prdata_q;
    assign wr_strobe  = wr_strobe_q;
    assign wr_idx     = wr_idx_q;

    // Register 0 is the read-only ID word; its storage slot is never written.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
        if (gi == 0) begin : g_id
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = ID_VALUE;
        end else begin : g_rw
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_q[gi];
        end
    end
endmodule
`default_nettype wire

// File: doc/apb2_slave_regs.md
# apb2_slave_regs

APB2 (AMBA 2, no PREADY/PSLVERR) responder terminating the bus driven by the APB2 master UVC: a bank of NUM_REGS word-wide registers with a bus-phase tracker. It is the DUT-side/reference-slave counterpart used in UVC self-tests and as a loopback target, and it exposes register contents and write strobes to local logic.

## Interface
- ADDR_WIDTH, 8, width of paddr
- DATA_WIDTH, 32, width of pwdata/prdata and each register
- NUM_REGS, 16, register count (power of 2, 2..256); register i at byte address 4*i
- ID_VALUE, 32'hA2B2_0001, constant returned by read-only register 0
- pclk  input  1  bus clock; all logic on rising edge
- preset  input  1  synchronous, active-high reset
- pselx  input  1  slave select
- pwrite  input  1  1 = write, 0 = read
- penable  input  1  access-phase qualifier
- paddr  input  ADDR_WIDTH  byte address
- pwdata  input  DATA_WIDTH  write data
- prdata  output  DATA_WIDTH  read data, valid during access phase
- reg_out  output  NUM_REGS*DATA_WIDTH  flat register image, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- wr_strobe  output  1  one-cycle pulse after a register write commits
- wr_idx  output  log2(NUM_REGS)  index of the register written, valid with wr_strobe
- prot_err  output  1  sticky protocol-violation flag
- err_count  output  8  saturating count of protocol violations
- err_clr  input  1  clears prot_err and err_count

## Operation
- Phase tracker FSM, states IDLE, SETUP, ACCESS:
  - IDLE: pselx=1, penable=0 -> SETUP; pselx=1, penable=1 -> violation, stay IDLE.
  - SETUP: pselx=1, penable=1, paddr/pwrite unchanged from setup -> ACCESS; any other input -> violation, next state from current inputs as in IDLE.
  - ACCESS (exactly one cycle in APB2): pselx=1, penable=0 -> SETUP (back-to-back); pselx=0 -> IDLE; pselx=1, penable=1 -> violation, IDLE.
- Decode: idx = paddr[log2(NUM_REGS)+1:2]; in range iff paddr < 4*NUM_REGS. paddr[1:0] ignored.
- Read: at the edge ending SETUP with pwrite=0, prdata <= register[idx] (register 0 returns ID_VALUE; out of range returns 0). prdata holds until the next read setup; no combinational path from bus to prdata.
- Write: commits at the edge ending a legal ACCESS with pwrite=1: register[idx] <= pwdata. Writes to register 0 or out-of-range addresses are dropped, no strobe. Illegal accesses never write.
- wr_strobe/wr_idx registered from the committing edge, one cycle high.
- Simultaneous err_clr and violation: violation wins (prot_err=1, err_count=1).
- err_count saturates at 255.

## Timing
- Reset (preset=1 at an edge): FSM IDLE; registers 1..NUM_REGS-1 = 0; prdata=0; wr_strobe=0; wr_idx=0; prot_err=0; err_count=0. Reset mid-transfer aborts it; the pending write is not committed.
- Read latency: data valid the cycle after setup, i.e. throughout the access cycle; master samples at the edge ending access.
- Write visible on reg_out the cycle after the access cycle; wr_strobe in that same cycle.
- Back-to-back transfers: one transfer per 2 cycles sustained; no wait states.

## Configuration
- APB2_SLAVE_PROT_CHECK_EN defined: FSM violation detection, prot_err, err_count, and err_clr active as above; illegal accesses do not write.
- Undefined: no checker; prot_err and err_count tie to 0, err_clr ignored; any cycle with pselx=1, penable=1 is treated as a legal access (writes commit, reads use the value latched on the previous penable=0 cycle).

## Test plan
- Reset, then read addr 0x00 -> prdata=32'hA2B2_0001 in access cycle; read addr 0x04 -> 0.
- Write 0xDEADBEEF to 0x08, read 0x08 -> prdata=0xDEADBEEF; wr_strobe one cycle, wr_idx=2; reg_out[95:64]=0xDEADBEEF.
- Back-to-back write 0x11 to 0x0C then read 0x0C with no idle cycle -> read returns 0x11.
- Write 0x55 to 0x00 and to 0x40 (out of range, NUM_REGS=16) -> no wr_strobe; reads return ID_VALUE and 0.
- With macro: penable=1 without setup, then access held two cycles -> err_count=2, prot_err=1, no register change; err_clr -> both 0.
- Assert preset during the access cycle of a write to 0x10 -> register 4 stays 0, all outputs at reset values next cycle.
